// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner: hex patterns, segment
// bit positions, scan phase type and the pin polarity helper.
package seg_pkg;

    localparam int SEG_W = 7;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high patterns, bit 0 = segment a through bit 6 = segment g
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        PHASE_BLANK,
        PHASE_DIGIT
    } phase_t;

    function automatic logic [SEG_W-1:0] seg_polarity(input logic [SEG_W-1:0] lit,
                                                     input logic active_low);
        return active_low ? ~lit : lit;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex-to-segment decoder; output is active-high and forced dark
// whenever blank is set.
import seg_pkg::*;

module seg_decode (
    input  logic [3:0]       nibble,
    input  logic             blank,
    output logic [SEG_W-1:0] seg
);

    logic [SEG_W-1:0] pattern;

    assign pattern = HEX_SEG[nibble];

    always_comb begin
        seg = '0;
        if (!blank) begin
            seg[SEG_A] = pattern[SEG_A];
            seg[SEG_B] = pattern[SEG_B];
            seg[SEG_C] = pattern[SEG_C];
            seg[SEG_D] = pattern[SEG_D];
            seg[SEG_E] = pattern[SEG_E];
            seg[SEG_F] = pattern[SEG_F];
            seg[SEG_G] = pattern[SEG_G];
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner with frame-synchronous shadow updates,
// per-slot anti-ghosting blanking and leading-zero suppression.
import seg_pkg::*;

module seg_scan #(
    parameter int DIGITS         = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en_in,
    input  logic                  lz_in,
    input  logic                  load,
    output logic [DIGITS-1:0]     sel_out,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp_out,
    output logic                  frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic SEL_INV = (SEL_ACTIVE_LOW != 0);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  last_cnt;
    logic                  boundary;

    logic [4*DIGITS-1:0]   pend_data, shd_data;
    logic [DIGITS-1:0]     pend_dp, shd_dp;
    logic [DIGITS-1:0]     pend_en, shd_en;
    logic                  pend_lz, shd_lz;

    logic [DIGITS-1:0]     suppress;
    logic                  chain;
    logic                  zero_nodp;

    phase_t                phase;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_en, cur_sup;
    logic                  blank_digit;
    logic [SEG_W-1:0]      seg_lit;
    logic [DIGITS-1:0]     sel_lit;
    logic                  dp_lit;

    assign last_cnt = (cnt == CW'(SCAN_DIV - 1));
    assign boundary = last_cnt && (idx == IW'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (last_cnt) begin
            cnt <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow takes the pre-edge pending value, so a load on the boundary
    // cycle lands in pending only and waits for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pend_en   <= '1;
            pend_lz   <= 1'b0;
            shd_data  <= '0;
            shd_dp    <= '0;
            shd_en    <= '1;
            shd_lz    <= 1'b0;
        end else begin
            if (load) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
                pend_en   <= en_in;
                pend_lz   <= lz_in;
            end
            if (boundary) begin
                shd_data <= pend_data;
                shd_dp   <= pend_dp;
                shd_en   <= pend_en;
                shd_lz   <= pend_lz;
            end
        end
    end

    // Disabled digits pass the suppression chain through regardless of value
    always_comb begin
        suppress  = '0;
        chain     = shd_lz;
        zero_nodp = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_nodp   = (shd_data[4*i +: 4] == 4'h0) && !shd_dp[i];
            suppress[i] = chain && zero_nodp;
            chain       = chain && (zero_nodp || !shd_en[i]);
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        cur_sup = 1'b0;
        sel_lit = '0;
        phase   = (cnt < CW'(BLANK_CYCLES)) ? PHASE_BLANK : PHASE_DIGIT;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib    = shd_data[4*i +: 4];
                cur_dp     = shd_dp[i];
                cur_en     = shd_en[i];
                cur_sup    = suppress[i];
                sel_lit[i] = (phase == PHASE_DIGIT);
            end
        end
        blank_digit = (phase == PHASE_BLANK) || !cur_en || cur_sup;
        dp_lit      = cur_dp && !blank_digit;
    end

    seg_decode u_decode (
        .nibble (cur_nib),
        .blank  (blank_digit),
        .seg    (seg_lit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_out    <= {DIGITS{SEL_INV}};
            seg        <= seg_polarity('0, SEG_INV);
            dp_out     <= SEG_INV;
            frame_done <= 1'b0;
        end else begin
            sel_out    <= sel_lit ^ {DIGITS{SEL_INV}};
            seg        <= seg_polarity(seg_lit, SEG_INV);
            dp_out     <= dp_lit ^ SEG_INV;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: two small configurations checked every
// cycle against a time-based reference model, plus the default-size reset check.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        lz_in;
    logic [23:0] data_in;
    logic [5:0]  dp_in;
    logic [5:0]  en_in;

    logic [5:0]  sel0;
    logic [6:0]  seg0;
    logic        dp0, fd0;
    logic [3:0]  sel1;
    logic [6:0]  seg1;
    logic        dp1, fd1;
    logic [5:0]  seld;
    logic [6:0]  segd;
    logic        dpd, fdd;

    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    seg_scan #(.DIGITS(6), .SCAN_DIV(8), .BLANK_CYCLES(2),
               .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) u_main (
        .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .en_in(en_in),
        .lz_in(lz_in), .load(load), .sel_out(sel0), .seg(seg0), .dp_out(dp0),
        .frame_done(fd0)
    );

    seg_scan #(.DIGITS(4), .SCAN_DIV(5), .BLANK_CYCLES(0),
               .SEL_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)) u_pol (
        .clk(clk), .rst(rst), .data_in(data_in[15:0]), .dp_in(dp_in[3:0]),
        .en_in(en_in[3:0]), .lz_in(lz_in), .load(load), .sel_out(sel1),
        .seg(seg1), .dp_out(dp1), .frame_done(fd1)
    );

    seg_scan u_def (
        .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .en_in(en_in),
        .lz_in(lz_in), .load(load), .sel_out(seld), .seg(segd), .dp_out(dpd),
        .frame_done(fdd)
    );

    // Reference model state, one slot per checked configuration
    int          cfg_d [2] = '{6, 4};
    int          cfg_s [2] = '{8, 5};
    int          cfg_b [2] = '{2, 0};
    logic        cfg_sel_al [2] = '{1'b1, 1'b0};
    logic        cfg_seg_al [2] = '{1'b1, 1'b0};

    int          mt [2];
    logic [31:0] pend_data [2], shd_data [2];
    logic [7:0]  pend_dp [2], shd_dp [2], pend_en [2], shd_en [2];
    logic        pend_lz [2], shd_lz [2];

    int          def_t    = 0;
    bit          def_done = 1'b0;

    logic [6:0]  hex_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] digit_mask(input int d);
        return 8'((1 << d) - 1);
    endfunction

    // The most significant "meaningful" digit is the highest enabled digit that
    // is nonzero or carries a dp; zero, dp-less digits above it go dark.
    function automatic bit is_suppressed(input int k, input int i);
        int top = 0;
        if (!shd_lz[k] || i == 0) return 1'b0;
        for (int j = cfg_d[k] - 1; j > 0; j--) begin
            if (shd_en[k][j] && (shd_data[k][4*j +: 4] != 4'h0 || shd_dp[k][j])) begin
                top = j;
                break;
            end
        end
        return (i > top) && (shd_data[k][4*i +: 4] == 4'h0) && !shd_dp[k][i];
    endfunction

    function automatic bit at_boundary(input int k);
        return (mt[k] % (cfg_s[k] * cfg_d[k])) == (cfg_s[k] * cfg_d[k] - 1);
    endfunction

    task automatic model_expect(input int k, output logic [7:0] es,
                                output logic [6:0] eg, output logic ed,
                                output logic ef);
        int         c, i;
        logic [7:0] lit_sel;
        logic [6:0] lit_seg;
        logic       lit_dp;
        lit_sel = '0;
        lit_seg = '0;
        lit_dp  = 1'b0;
        ef      = 1'b0;
        if (!rst) begin
            c  = mt[k] % cfg_s[k];
            i  = (mt[k] / cfg_s[k]) % cfg_d[k];
            ef = at_boundary(k);
            if (c >= cfg_b[k]) begin
                lit_sel = 8'(1 << i);
                if (shd_en[k][i] && !is_suppressed(k, i)) begin
                    lit_seg = hex_tab[shd_data[k][4*i +: 4]];
                    lit_dp  = shd_dp[k][i];
                end
            end
        end
        es = cfg_sel_al[k] ? (~lit_sel & digit_mask(cfg_d[k])) : lit_sel;
        eg = cfg_seg_al[k] ? ~lit_seg : lit_seg;
        ed = lit_dp ^ cfg_seg_al[k];
    endtask

    task automatic model_update(input int k);
        logic [31:0] dmask;
        dmask = 32'((64'd1 << (4 * cfg_d[k])) - 1);
        if (rst) begin
            mt[k]        = 0;
            pend_data[k] = '0;
            pend_dp[k]   = '0;
            pend_en[k]   = digit_mask(cfg_d[k]);
            pend_lz[k]   = 1'b0;
            shd_data[k]  = '0;
            shd_dp[k]    = '0;
            shd_en[k]    = digit_mask(cfg_d[k]);
            shd_lz[k]    = 1'b0;
        end else begin
            if (at_boundary(k)) begin
                shd_data[k] = pend_data[k];
                shd_dp[k]   = pend_dp[k];
                shd_en[k]   = pend_en[k];
                shd_lz[k]   = pend_lz[k];
            end
            if (load) begin
                pend_data[k] = 32'(data_in) & dmask;
                pend_dp[k]   = 8'(dp_in) & digit_mask(cfg_d[k]);
                pend_en[k]   = 8'(en_in) & digit_mask(cfg_d[k]);
                pend_lz[k]   = lz_in;
            end
            mt[k]++;
        end
    endtask

    task automatic tick();
        logic [7:0] es [2];
        logic [6:0] eg [2];
        logic       ed [2];
        logic       ef [2];
        for (int k = 0; k < 2; k++) model_expect(k, es[k], eg[k], ed[k], ef[k]);
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k);
        if (!def_done) def_t = rst ? 0 : def_t + 1;
        #1;
        checkOutput("main_sel", 32'(sel0), 32'(es[0]));
        checkOutput("main_seg", 32'(seg0), 32'(eg[0]));
        checkOutput("main_dp",  32'(dp0),  32'(ed[0]));
        checkOutput("main_fd",  32'(fd0),  32'(ef[0]));
        checkOutput("pol_sel",  32'(sel1), 32'(es[1]));
        checkOutput("pol_seg",  32'(seg1), 32'(eg[1]));
        checkOutput("pol_dp",   32'(dp1),  32'(ed[1]));
        checkOutput("pol_fd",   32'(fd1),  32'(ef[1]));
        if (!def_done) begin
            if (def_t <= 500) begin
                checkOutput("def_idle_sel", 32'(seld), 32'h3F);
                checkOutput("def_idle_seg", 32'(segd), 32'h7F);
            end else begin
                checkOutput("def_first_sel", 32'(seld), 32'h3E);
                def_done = 1'b1;
            end
        end
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic [23:0] d, input logic [5:0] dp,
                                 input logic [5:0] en, input logic lz);
        data_in = d;
        dp_in   = dp;
        en_in   = en;
        lz_in   = lz;
        load    = 1'b1;
    endtask

    initial begin
        int shift;
        rst     = 1'b1;
        load    = 1'b0;
        lz_in   = 1'b0;
        data_in = '0;
        dp_in   = '0;
        en_in   = 6'h3F;
        run(3);
        rst = 1'b0;

        run(10);
        applyStimulus(24'h123456, 6'h00, 6'h3F, 1'b0);
        run(500);

        applyStimulus(24'h000100, 6'h00, 6'h3F, 1'b1);
        run(100);
        applyStimulus(24'h000100, 6'b010000, 6'h3F, 1'b1);
        run(100);

        applyStimulus(24'h222222, 6'h00, 6'h3F, 1'b0);
        run(100);
        for (int w = 0; w < 48 && (mt[0] % 48) != 20; w++) tick();
        applyStimulus(24'h111111, 6'h00, 6'h3F, 1'b0);
        run(100);
        for (int w = 0; w < 48 && (mt[0] % 48) != 47; w++) tick();
        applyStimulus(24'h333333, 6'h00, 6'h3F, 1'b0);
        run(100);

        applyStimulus(24'h888888, 6'h00, 6'b111011, 1'b0);
        run(100);
        applyStimulus(24'hABCDEF, 6'h3F, 6'h3F, 1'b0);
        run(60);

        for (int w = 0; w < 48 && !(((mt[0] / 8) % 6) == 3 && (mt[0] % 8) == 4); w++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(60);

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            shift = $urandom_range(0, 6);
            applyStimulus(24'($urandom()) >> (4 * shift),
                          ($urandom_range(0, 2) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'h00,
                          ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'h3F,
                          1'($urandom_range(0, 1)));
            run($urandom_range(1, 70));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
